// File: rtl/s3g_uart_tx_if.sv
// Byte write interface between the S3G packet framer (master) and the UART transmitter (slave).
// tx_wr is a one-cycle strobe with no ready. busy high means a new write is held behind the current frame, or dropped if the hold register is already full.
interface s3g_uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_done;
  logic       busy;
  logic       overrun;

  modport master (output tx_data, output tx_wr, input tx_done, input busy, input overrun);
  modport slave  (input tx_data, input tx_wr, output tx_done, output busy, output overrun);
endinterface

// File: rtl/s3g_uart_tx.sv
// 8N1/8N2 UART transmitter with a one-byte holding register for back-to-back frames.
// Define S3G_UART_TX_PARITY_EN to insert an even-parity bit between the MSB and the stop bits.
module s3g_uart_tx #(
  parameter int CLK_DIV   = 434,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  s3g_uart_tx_if.slave      bus,
  output logic              txd,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef S3G_UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  localparam logic [15:0] DIV_M1    = 16'(CLK_DIV - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_valid_q, hold_valid_d;
  logic        txd_q, txd_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;
`ifdef S3G_UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  logic        bit_end;
  logic        stop_end;
  logic        load_en;
  logic [7:0]  load_byte;

  assign bit_end = (baud_q == DIV_M1);

  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    overrun_d    = overrun_q;
    done_d       = 1'b0;
    stop_end     = 1'b0;
    load_en      = 1'b0;
    load_byte    = bus.tx_data;
`ifdef S3G_UART_TX_PARITY_EN
    par_d        = par_q;
`endif

    if (state_q != ST_IDLE) baud_d = bit_end ? 16'd0 : baud_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        baud_d = 16'd0;
        if (bus.tx_wr) load_en = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
`ifdef S3G_UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef S3G_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          bit_d   = 3'd0;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == LAST_STOP) stop_end = 1'b1;
          else                    bit_d = bit_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A write landing on the stop-end edge chains straight into the next frame when the hold is empty.
    if (stop_end) begin
      done_d = 1'b1;
      if (hold_valid_q) begin
        load_en      = 1'b1;
        load_byte    = hold_q;
        hold_valid_d = 1'b0;
        if (bus.tx_wr) overrun_d = 1'b1;
      end else if (bus.tx_wr) begin
        load_en = 1'b1;
      end else begin
        state_d = ST_IDLE;
        bit_d   = 3'd0;
      end
    end else if ((state_q != ST_IDLE) && bus.tx_wr) begin
      if (hold_valid_q) begin
        overrun_d = 1'b1;
      end else begin
        hold_d       = bus.tx_data;
        hold_valid_d = 1'b1;
      end
    end

    if (load_en) begin
      state_d = ST_START;
      baud_d  = 16'd0;
      bit_d   = 3'd0;
      shift_d = load_byte;
`ifdef S3G_UART_TX_PARITY_EN
      par_d   = ^load_byte;
`endif
    end

    // txd is registered, so it is computed from the state being entered.
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef S3G_UART_TX_PARITY_EN
      ST_PARITY: txd_d = par_d;
`endif
      default:   txd_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE) || hold_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      baud_q       <= 16'd0;
      bit_q        <= 3'd0;
      shift_q      <= 8'd0;
      hold_q       <= 8'd0;
      hold_valid_q <= 1'b0;
      txd_q        <= 1'b1;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef S3G_UART_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      txd_q        <= txd_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
`ifdef S3G_UART_TX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign txd         = txd_q;
  assign bus.tx_done = done_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;
  assign dbg_state   = state_q;

endmodule
